// File: rtl/deserializer_align_msb.sv
// -----------------------------------------------------------------------------
// deserializer_align_msb
//
// MSB-first serial-to-parallel receiver with word alignment. Each enabled
// rising edge of bitCK shifts one bit in. While unlocked, the receiver looks
// for SYNCWORD at every bit offset. It locks after LOCKCOUNT consecutive sync
// words that sit on the same word boundary. Once locked, every aligned word is
// presented on dout with a one-cycle dvalid strobe.
//
// Parameters
//   WORDWIDTH : word length in bits (>= 4)
//   SYNCWORD  : alignment pattern, transmitted MSB first
//   LOCKCOUNT : consecutive aligned sync words needed to lock (1..15)
//
// Ports
//   bitCK   in   bit clock; all state changes on its rising edge
//   rstn    in   asynchronous active-low reset
//   enable  in   bit qualifier; when low all state holds and dvalid is 0
//   sin     in   serial data, MSB of each word first
//   resync  in   request to drop lock and search again (used only when enable)
//   dout    out  last aligned word (registered)
//   dvalid  out  one-cycle strobe: dout updated this cycle
//   isSync  out  dout equals SYNCWORD
//   locked  out  high in the LOCKED state
// -----------------------------------------------------------------------------
module deserializer_align_msb #(
  parameter int                   WORDWIDTH = 8,
  parameter logic [WORDWIDTH-1:0] SYNCWORD  = 8'hE4,
  parameter int                   LOCKCOUNT = 3
) (
  input  logic                 bitCK,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 sin,
  input  logic                 resync,
  output logic [WORDWIDTH-1:0] dout,
  output logic                 dvalid,
  output logic                 isSync,
  output logic                 locked
);

  localparam int             BCW     = $clog2(WORDWIDTH);
  localparam logic [BCW-1:0] BC_LAST = BCW'(WORDWIDTH - 1);
  localparam logic [3:0]     LC      = 4'(LOCKCOUNT);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t               r_state;
  // Only WORDWIDTH-1 history bits are needed: the candidate word is the
  // history plus the bit arriving on this edge.
  logic [WORDWIDTH-2:0] r_shift;
  logic [BCW-1:0]       r_bc;
  logic [3:0]           r_sc;
  logic [WORDWIDTH-1:0] r_dout;
  logic                 r_dvalid;
  logic                 r_issync;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  state_t               w_state_next;
  logic [WORDWIDTH-2:0] w_shift_next;
  logic [BCW-1:0]       w_bc_next;
  logic [3:0]           w_sc_next;
  logic [WORDWIDTH-1:0] w_dout_next;
  logic                 w_dvalid_next;
  logic                 w_issync_next;

  logic [WORDWIDTH-1:0] w_word;
  logic                 w_is_sync;
  logic                 w_boundary;
  logic [BCW-1:0]       w_bc_inc;
  logic [3:0]           w_sc_inc;

  assign w_word     = {r_shift, sin};
  assign w_is_sync  = (w_word == SYNCWORD);
  assign w_boundary = (r_bc == BC_LAST);
  assign w_bc_inc   = r_bc + BCW'(1);
  assign w_sc_inc   = r_sc + 4'd1;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_bc_next     = r_bc;
    w_sc_next     = r_sc;
    w_dout_next   = r_dout;
    w_issync_next = r_issync;
    // The strobe lasts one edge, whether or not the next edge is enabled.
    w_dvalid_next = 1'b0;

    if (enable) begin
      // The shifter runs on every enabled edge, including resync edges.
      w_shift_next = {r_shift[WORDWIDTH-3:0], sin};

      if (resync) begin
        // Resync wins over any boundary action, so a coincident locked
        // boundary produces no strobe and leaves dout untouched.
        w_state_next = ST_SEARCH;
        w_bc_next    = '0;
        w_sc_next    = 4'd0;
      end else begin
        case (r_state)
          ST_SEARCH: begin
            // bc is a fill counter here: it saturates at WORDWIDTH-1 so that
            // once the shifter is full every edge tests a new bit offset.
            if (!w_boundary) begin
              w_bc_next = w_bc_inc;
            end else if (w_is_sync) begin
              w_bc_next = '0;
              w_sc_next = 4'd1;
              if (LC == 4'd1) begin
                // Single-word lock: the sync word itself is emitted.
                w_state_next  = ST_LOCKED;
                w_dout_next   = w_word;
                w_dvalid_next = 1'b1;
                w_issync_next = 1'b1;
              end else begin
                w_state_next = ST_CONFIRM;
              end
            end
          end

          ST_CONFIRM: begin
            if (!w_boundary) begin
              w_bc_next = w_bc_inc;
            end else if (w_is_sync) begin
              w_bc_next = '0;
              w_sc_next = w_sc_inc;
              if (w_sc_inc == LC) begin
                // The LOCKCOUNT-th sync word is emitted on the locking edge.
                w_state_next  = ST_LOCKED;
                w_dout_next   = w_word;
                w_dvalid_next = 1'b1;
                w_issync_next = 1'b1;
              end
            end else begin
              // Broken sequence: restart the hunt from an empty fill.
              w_state_next = ST_SEARCH;
              w_bc_next    = '0;
              w_sc_next    = 4'd0;
            end
          end

          ST_LOCKED: begin
            if (!w_boundary) begin
              w_bc_next = w_bc_inc;
            end else begin
              // Data words never break lock; every boundary is emitted.
              w_bc_next     = '0;
              w_dout_next   = w_word;
              w_dvalid_next = 1'b1;
              w_issync_next = w_is_sync;
            end
          end

          default: begin
            w_state_next = ST_SEARCH;
            w_bc_next    = '0;
            w_sc_next    = 4'd0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge bitCK or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_SEARCH;
      r_shift  <= '0;
      r_bc     <= '0;
      r_sc     <= 4'd0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_issync <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_shift  <= w_shift_next;
      r_bc     <= w_bc_next;
      r_sc     <= w_sc_next;
      r_dout   <= w_dout_next;
      r_dvalid <= w_dvalid_next;
      r_issync <= w_issync_next;
    end
  end

  assign dout   = r_dout;
  assign dvalid = r_dvalid;
  assign isSync = r_issync;
  assign locked = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_deserializer_align_msb.sv
// -----------------------------------------------------------------------------
// tb_deserializer_align_msb
//
// Directed bench for deserializer_align_msb with default parameters
// (8-bit words, sync E4, lock after 3 sync words). Inputs change 1 time unit
// after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_deserializer_align_msb;

  logic       bitCK;
  logic       rstn;
  logic       enable;
  logic       sin;
  logic       resync;
  logic [7:0] dout;
  logic       dvalid;
  logic       isSync;
  logic       locked;

  int n_checks;
  int n_fail;
  int cyc;
  int dv_count;
  int t_prev;
  int dv_snap;

  deserializer_align_msb #(
    .WORDWIDTH (8),
    .SYNCWORD  (8'hE4),
    .LOCKCOUNT (3)
  ) dut (
    .bitCK  (bitCK),
    .rstn   (rstn),
    .enable (enable),
    .sin    (sin),
    .resync (resync),
    .dout   (dout),
    .dvalid (dvalid),
    .isSync (isSync),
    .locked (locked)
  );

  initial begin
    bitCK = 1'b0;
    forever #5 bitCK = ~bitCK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One bit period: drive, clock, sample 1 unit after the edge.
  task automatic send_bit(input logic b, input logic en, input logic rs);
    enable = en;
    sin    = b;
    resync = rs;
    @(posedge bitCK);
    #1;
    cyc++;
    if (dvalid) dv_count++;
    if (!en) check("dv_while_en_low", {31'd0, dvalid}, 32'd0);
    resync = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic rs_lsb);
    for (int i = 7; i >= 0; i--)
      send_bit(w[i], 1'b1, (i == 0) ? rs_lsb : 1'b0);
    $display("word %02h rs=%0d -> dout=%02h dvalid=%0d isSync=%0d locked=%0d",
             w, rs_lsb, dout, dvalid, isSync, locked);
  endtask

  initial begin
    logic [7:0] junk;
    logic [7:0] dat;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    dv_count = 0;
    t_prev   = 0;
    rstn     = 1'b0;
    enable   = 1'b1;
    sin      = 1'b0;
    resync   = 1'b0;

    // ---- Reset / idle ----
    repeat (3) @(posedge bitCK);
    #1;
    check("rst_dout",   {24'd0, dout},   32'd0);
    check("rst_dvalid", {31'd0, dvalid}, 32'd0);
    check("rst_issync", {31'd0, isSync}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) send_bit(1'b0, 1'b1, 1'b0);
    check("idle_dv_count", dv_count, 0);
    check("idle_locked",   {31'd0, locked}, 32'd0);
    check("idle_dout",     {24'd0, dout},   32'd0);

    // ---- Lock at offset: junk 101 then E4,E4,E4,3C,E4 ----
    junk = 8'b0000_0101;
    for (int i = 2; i >= 0; i--) send_bit(junk[i], 1'b1, 1'b0);
    send_word(8'hE4, 1'b0);
    check("off_w1_locked", {31'd0, locked}, 32'd0);
    send_word(8'hE4, 1'b0);
    check("off_w2_locked", {31'd0, locked}, 32'd0);
    check("off_no_dv_prelock", dv_count, 0);
    send_word(8'hE4, 1'b0);
    check("off_w3_locked", {31'd0, locked}, 32'd1);
    check("off_w3_dvalid", {31'd0, dvalid}, 32'd1);
    check("off_w3_issync", {31'd0, isSync}, 32'd1);
    check("off_w3_dout",   {24'd0, dout},   32'hE4);
    t_prev = cyc;
    send_word(8'h3C, 1'b0);
    check("off_3c_dvalid", {31'd0, dvalid}, 32'd1);
    check("off_3c_dout",   {24'd0, dout},   32'h3C);
    check("off_3c_issync", {31'd0, isSync}, 32'd0);
    check("off_3c_period", cyc - t_prev, 8);
    t_prev = cyc;
    send_word(8'hE4, 1'b0);
    check("off_e4_dvalid", {31'd0, dvalid}, 32'd1);
    check("off_e4_issync", {31'd0, isSync}, 32'd1);
    check("off_e4_period", cyc - t_prev, 8);
    check("off_dv_count",  dv_count, 3);
    t_prev = cyc;

    // ---- Enable gating: 81 with enable low 5 cycles mid-word ----
    dat = 8'h81;
    for (int i = 7; i >= 4; i--) send_bit(dat[i], 1'b1, 1'b0);
    repeat (5) send_bit(1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) send_bit(dat[i], 1'b1, 1'b0);
    $display("word 81 gated -> dout=%02h dvalid=%0d isSync=%0d locked=%0d",
             dout, dvalid, isSync, locked);
    check("en_dout",   {24'd0, dout},   32'h81);
    check("en_dvalid", {31'd0, dvalid}, 32'd1);
    check("en_issync", {31'd0, isSync}, 32'd0);
    check("en_period", cyc - t_prev, 13);
    t_prev = cyc;
    // Strobe must clear on the next edge even with enable low.
    repeat (2) send_bit(1'b0, 1'b0, 1'b0);
    check("en_dout_hold", {24'd0, dout}, 32'h81);
    send_word(8'hE4, 1'b0);
    check("en_e4_period", cyc - t_prev, 10);
    check("en_e4_dout",   {24'd0, dout}, 32'hE4);

    // ---- Resync on a locked LSB edge ----
    dv_snap = dv_count;
    send_word(8'hA5, 1'b1);
    check("rs_dvalid", {31'd0, dvalid}, 32'd0);
    check("rs_dout",   {24'd0, dout},   32'hE4);
    check("rs_locked", {31'd0, locked}, 32'd0);
    check("rs_dv_count", dv_count, dv_snap);
    send_word(8'hE4, 1'b0);
    check("rs_w1_locked", {31'd0, locked}, 32'd0);
    send_word(8'hE4, 1'b0);
    check("rs_w2_locked", {31'd0, locked}, 32'd0);
    send_word(8'hE4, 1'b0);
    check("rs_w3_locked", {31'd0, locked}, 32'd1);
    check("rs_w3_dvalid", {31'd0, dvalid}, 32'd1);

    // ---- Async reset mid-lock, right after a strobe ----
    #2;
    rstn = 1'b0;
    #1;
    check("ar_dout",   {24'd0, dout},   32'd0);
    check("ar_dvalid", {31'd0, dvalid}, 32'd0);
    check("ar_issync", {31'd0, isSync}, 32'd0);
    check("ar_locked", {31'd0, locked}, 32'd0);
    @(posedge bitCK);
    #1;
    rstn = 1'b1;

    // ---- Failed confirm: E4,E4,5A,E4,E4,E4 ----
    dv_snap = dv_count;
    send_word(8'hE4, 1'b0);
    check("fc_w1_locked", {31'd0, locked}, 32'd0);
    send_word(8'hE4, 1'b0);
    check("fc_w2_locked", {31'd0, locked}, 32'd0);
    send_word(8'h5A, 1'b0);
    check("fc_5a_locked", {31'd0, locked}, 32'd0);
    send_word(8'hE4, 1'b0);
    check("fc_w4_locked", {31'd0, locked}, 32'd0);
    send_word(8'hE4, 1'b0);
    check("fc_w5_locked", {31'd0, locked}, 32'd0);
    check("fc_no_dv", dv_count, dv_snap);
    send_word(8'hE4, 1'b0);
    check("fc_w6_locked", {31'd0, locked}, 32'd1);
    check("fc_w6_dvalid", {31'd0, dvalid}, 32'd1);
    check("fc_w6_issync", {31'd0, isSync}, 32'd1);
    check("fc_w6_dout",   {24'd0, dout},   32'hE4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
